// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between the CPU
// memory port and the loader port; one SRAM cycle per transaction.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_done,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              ce_q, ce_d;
    logic              sram_we_q, sram_we_d;
    logic              cpu_done_q, cpu_done_d;
    logic              ldr_done_q, ldr_done_d;
    logic              busy_q, busy_d;
    logic              grant_ldr_c;

    // Loader wins when it is the only requester, or on a tie when the CPU was served last.
    assign grant_ldr_c = ldr_req && (!cpu_req || !last_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        ce_d        = 1'b0;
        sram_we_d   = 1'b0;
        cpu_done_d  = 1'b0;
        ldr_done_d  = 1'b0;
        busy_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    owner_d   = grant_ldr_c;
                    we_d      = grant_ldr_c ? ldr_we    : cpu_we;
                    addr_d    = grant_ldr_c ? ldr_addr  : cpu_addr;
                    wdata_d   = grant_ldr_c ? ldr_wdata : cpu_wdata;
                    ce_d      = 1'b1;
                    sram_we_d = we_d;
                    busy_d    = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                busy_d = 1'b1;
                if (we_q) begin
                    cpu_done_d = !owner_q;
                    ldr_done_d = owner_q;
                    state_d    = DONE;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    if (owner_q) begin
                        ldr_rdata_d = sram_rdata;
                    end else begin
                        cpu_rdata_d = sram_rdata;
                    end
                    cpu_done_d = !owner_q;
                    ldr_done_d = owner_q;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            ce_q        <= 1'b0;
            sram_we_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            ldr_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            ce_q        <= ce_d;
            sram_we_q   <= sram_we_d;
            cpu_done_q  <= cpu_done_d;
            ldr_done_q  <= ldr_done_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_done   = cpu_done_q;
    assign ldr_rdata  = ldr_rdata_q;
    assign ldr_done   = ldr_done_q;
    assign sram_ce    = ce_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign busy       = busy_q;
    assign owner      = owner_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port synchronous program/data SRAM between two requesters: the SLC-3 CPU memory port and the program-loader/IO port. It serializes their accesses with round-robin arbitration and issues one SRAM cycle per transaction. It waits out the fixed SRAM read latency and returns read data with a one-cycle done pulse to the owning requester. It sits between the CPU's MAR/MDR memory signals, the loader, and the SRAM.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- RD_LAT, 2, SRAM read latency in cycles, legal 1..7
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- cpu_req  in  1  CPU transaction request, level
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address (MAR)
- cpu_wdata  in  DATA_W  CPU write data (MDR)
- cpu_rdata  out  DATA_W  last read data returned to the CPU
- cpu_done  out  1  one-cycle completion pulse
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_done: same meaning as the cpu_* ports, for the loader port
- sram_ce  out  1  SRAM chip enable, one cycle per access
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after the sram_ce cycle
- busy  out  1  1 whenever state is not IDLE
- owner  out  1  0 = CPU, 1 = loader; the current or last granted port

## Operation
- State machine: IDLE, ISSUE, WAIT, DONE.
- Requester protocol:
  - Assert req with we, addr and wdata stable until the cycle its done pulses.
  - In the cycle after done, req must be deasserted or must present the next transaction.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not `last` (the last-served register).
  - On the grant edge, latch owner, we, addr and wdata internally, then go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (1 cycle):
  - sram_ce=1, sram_we=latched we; sram_addr and sram_wdata come from the latches.
  - Write: go to DONE.
  - Read: go to WAIT with cnt=1.
- WAIT:
  - cnt increments each cycle.
  - When cnt==RD_LAT, capture sram_rdata into the owner's rdata register on that edge and go to DONE.
- DONE (1 cycle):
  - Assert done for the owner only.
  - On the exit edge, update last=owner, then go to IDLE.
- Outputs outside ISSUE: sram_ce=0 and sram_we=0; sram_addr and sram_wdata hold their latched values.
- Per-port rdata:
  - Changes only on that port's read completions.
  - Valid in the done cycle and holds until that port's next read completion.
  - Write transactions leave rdata unchanged.
- Non-owner port outputs are unaffected by the other port's transaction.
- Dropping req mid-transaction does not abort it: the transaction completes and done still pulses.
- Changing we, addr or wdata mid-transaction has no effect, because the values were latched at grant.

## Timing
- Reset values:
  - State IDLE, cnt=0, last=1 (CPU wins the first tie).
  - All outputs 0: sram_*, *_rdata, *_done, busy, owner.
- Reset mid-transaction: abort immediately, no done pulse, no SRAM access completes. The requester must reissue after reset deasserts.
- Write latency: req seen in IDLE at cycle 0, ISSUE at 1, done at 2.
- Read latency: req seen in IDLE at cycle 0, ISSUE at 1, WAIT at 2..1+RD_LAT, done at 2+RD_LAT. With the default RD_LAT=2, done is at 4.
- Minimum spacing: one IDLE cycle between transactions.
  - Back-to-back writes: one per 3 cycles.
  - Back-to-back reads: one per RD_LAT+3 cycles.
- Fairness: with both ports continuously requesting, grants strictly alternate. A port waits at most one full other-port transaction.
- busy is high from ISSUE through DONE inclusive.

## Test plan
- Reset, then CPU read of 0x0010 (SRAM model holds 0xBEEF, RD_LAT=2) -> sram_ce=1, sram_we=0, sram_addr=0x0010 in cycle 1; cpu_done in cycle 4 with cpu_rdata=0xBEEF; ldr_done stays 0.
- Loader write of 0x1234 to 0x3000 -> sram_ce=1, sram_we=1 with addr 0x3000 and data 0x1234 in cycle 1; ldr_done in cycle 2. A following CPU read of 0x3000 returns 0x1234.
- Both req held high from reset release -> grants go CPU, loader, CPU, loader; no port is served twice consecutively; each done pulses exactly once per grant.
- reset driven low during WAIT of a CPU read -> all outputs go to 0 asynchronously and no cpu_done is seen. After release, a fresh read completes with nominal latency.
- RD_LAT=1 and RD_LAT=7 builds -> read done at cycles 3 and 9 respectively; write done stays at cycle 2.
- CPU changes cpu_addr from 0x0020 to 0x0040 during WAIT and drops cpu_req -> SRAM saw 0x0020, cpu_done still pulses with data from 0x0020, and the arbiter then idles.
